// File: rtl/pll_phase_step_ctrl.sv
// Dynamic phase-step sequencer for the ECP5 EHXPLLL (PHASESEL/DIR/STEP/LOADREG).
// Define PLL_PHASE_TRACK_EN to add per-output phase position tracking (phase_pos, pos_clr).
module pll_phase_step_ctrl #(
  parameter int STEP_HOLD     = 4,
  parameter int SETUP_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int CNT_W         = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_sel,
  input  logic             req_dir,
  input  logic [CNT_W-1:0] req_count,
  input  logic             err_clr,
  input  logic             pll_locked,
  output logic [1:0]       phasesel,
  output logic             phasedir,
  output logic             phasestep,
  output logic             phaseloadreg,
  output logic             busy,
  output logic             done,
  output logic             error
`ifdef PLL_PHASE_TRACK_EN
  ,
  input  logic             pos_clr,
  output logic [3:0][7:0]  phase_pos
`endif
);

  // state     | meaning
  // IDLE      | waiting for a request
  // SETUP     | sel/dir stable before first PHASESTEP fall
  // STEP_LO   | PHASESTEP low
  // STEP_HI   | PHASESTEP high, step completes at end
  // SETTLE    | wait after last pulse
  // WAIT_LOCK | wait for lock, bounded by LOCK_TIMEOUT
  // DONE      | one-cycle completion
  typedef enum logic [2:0] {
    IDLE, SETUP, STEP_LO, STEP_HI, SETTLE, WAIT_LOCK, DONE
  } stateT;

  localparam int MAX_A   = (STEP_HOLD > SETUP_CYCLES) ? STEP_HOLD : SETUP_CYCLES;
  localparam int MAX_B   = (SETTLE_CYCLES > LOCK_TIMEOUT) ? SETTLE_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_DUR = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TMR_W   = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

  stateT            state, stateNext;
  logic [TMR_W-1:0] timer, tmrLoad;
  logic [CNT_W-1:0] remain, remainNext;
  logic             lockMeta, lockS;
  logic             accept, tmrZero, setErr;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      lockMeta <= 1'b0;
      lockS    <= 1'b0;
    end else begin
      lockMeta <= pll_locked;
      lockS    <= lockMeta;
    end
  end

  assign req_ready    = (state == IDLE) && lockS && !error;
  assign accept       = req_valid && req_ready;
  assign tmrZero      = (timer == '0);
  assign phaseloadreg = 1'b1;

  always_comb begin
    stateNext  = state;
    remainNext = remain;
    setErr     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          remainNext = req_count;
          stateNext  = (req_count == '0) ? DONE : SETUP;
        end
      end
      SETUP:   if (tmrZero) stateNext = STEP_LO;
      STEP_LO: if (tmrZero) stateNext = STEP_HI;
      STEP_HI: begin
        if (tmrZero) begin
          if (remain != '0) remainNext = remain - CNT_W'(1);
          stateNext = ((remainNext != '0) && lockS) ? STEP_LO : SETTLE;
        end
      end
      SETTLE:  if (tmrZero) stateNext = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lockS) begin
          stateNext = DONE;
        end else if (tmrZero) begin
          setErr    = 1'b1;
          stateNext = IDLE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Timer is reloaded on every state entry with that state's dwell minus one.
  always_comb begin
    tmrLoad = '0;
    case (stateNext)
      SETUP:     tmrLoad = TMR_W'(SETUP_CYCLES - 1);
      STEP_LO:   tmrLoad = TMR_W'(STEP_HOLD - 1);
      STEP_HI:   tmrLoad = TMR_W'(STEP_HOLD - 1);
      SETTLE:    tmrLoad = TMR_W'(SETTLE_CYCLES - 1);
      WAIT_LOCK: tmrLoad = TMR_W'(LOCK_TIMEOUT - 1);
      default:   tmrLoad = '0;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      timer     <= '0;
      remain    <= '0;
      phasesel  <= 2'd0;
      phasedir  <= 1'b1;
      phasestep <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state  <= stateNext;
      remain <= remainNext;
      if (stateNext != state) timer <= tmrLoad;
      else if (!tmrZero)      timer <= timer - TMR_W'(1);
      if (accept) begin
        phasesel <= req_sel;
        phasedir <= req_dir;
      end
      // Outputs registered from the next state so they are glitch-free at the PLL pins.
      phasestep <= (stateNext != STEP_LO);
      busy      <= (stateNext != IDLE);
      done      <= (stateNext == DONE);
      if (setErr)                       error <= 1'b1;
      else if (state == IDLE && err_clr) error <= 1'b0;
    end
  end

`ifdef PLL_PHASE_TRACK_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      phase_pos <= '0;
    end else if (state == IDLE && pos_clr) begin
      phase_pos <= '0;
    end else if (state == STEP_HI && tmrZero) begin
      phase_pos[phasesel] <= phase_pos[phasesel] + (phasedir ? 8'd1 : 8'hFF);
    end
  end
`endif

endmodule

// File: tb/tb_pll_phase_step_ctrl.sv
// Scoreboard bench for pll_phase_step_ctrl: expectations queued at request, compared at completion.
module tb_pll_phase_step_ctrl;
  localparam int STEP_HOLD     = 4;
  localparam int SETUP_CYCLES  = 2;
  localparam int SETTLE_CYCLES = 16;
  localparam int LOCK_TIMEOUT  = 4096;
  localparam int CNT_W         = 8;

  logic             clock = 1'b0;
  logic             resetn = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_sel = 2'd0;
  logic             req_dir = 1'b0;
  logic [CNT_W-1:0] req_count = '0;
  logic             err_clr = 1'b0;
  logic             pll_locked = 1'b0;
  logic [1:0]       phasesel;
  logic             phasedir, phasestep, phaseloadreg, busy, done, error;
`ifdef PLL_PHASE_TRACK_EN
  logic             pos_clr = 1'b0;
  logic [3:0][7:0]  phase_pos;
`endif

  always #5 clock = ~clock;

  pll_phase_step_ctrl #(
    .STEP_HOLD(STEP_HOLD), .SETUP_CYCLES(SETUP_CYCLES), .SETTLE_CYCLES(SETTLE_CYCLES),
    .LOCK_TIMEOUT(LOCK_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_dir(req_dir), .req_count(req_count), .err_clr(err_clr),
    .pll_locked(pll_locked), .phasesel(phasesel), .phasedir(phasedir),
    .phasestep(phasestep), .phaseloadreg(phaseloadreg), .busy(busy), .done(done),
    .error(error)
`ifdef PLL_PHASE_TRACK_EN
    , .pos_clr(pos_clr), .phase_pos(phase_pos)
`endif
  );

  typedef struct {
    logic [1:0] sel;
    logic       dir;
    int         pulses;
    int         busyCyc;
    bit         expDone;
  } expT;

  expT sbQ[$];
  int  passCnt = 0;
  int  checkCnt = 0;

  // Monitor: observations of the PLL-side waveform for the current busy window.
  int         pulseCnt = 0, badLow = 0, badHigh = 0, lowRun = 0, highRun = 0;
  int         busyCyc = 0, firstFall = -1, doneCyc = 0;
  logic [1:0] selAtStart = 2'd0;
  logic       dirAtStart = 1'b0;
  bit         selChanged = 0, loadLow = 0;
  logic       prevStep = 1'b1, prevBusy = 1'b0;

  always @(negedge clock) begin
    if (busy && !prevBusy) begin
      busyCyc    <= 1;
      pulseCnt   <= 0;
      badLow     <= 0;
      badHigh    <= 0;
      lowRun     <= 0;
      highRun    <= 0;
      firstFall  <= -1;
      doneCyc    <= done ? 1 : 0;
      selAtStart <= phasesel;
      dirAtStart <= phasedir;
      selChanged <= 0;
      loadLow    <= (phaseloadreg !== 1'b1);
    end else begin
      if (busy) busyCyc <= busyCyc + 1;
      if (busy && (phasesel !== selAtStart || phasedir !== dirAtStart)) selChanged <= 1;
      if (done) doneCyc <= doneCyc + 1;
      if (phaseloadreg !== 1'b1) loadLow <= 1;
      if (prevStep && !phasestep) begin
        if (pulseCnt == 0) firstFall <= busyCyc;
        else if (highRun != STEP_HOLD) badHigh <= badHigh + 1;
        pulseCnt <= pulseCnt + 1;
        lowRun   <= 1;
      end else if (!prevStep && !phasestep) begin
        lowRun <= lowRun + 1;
      end else if (!prevStep && phasestep) begin
        if (lowRun != STEP_HOLD) badLow <= badLow + 1;
        highRun <= 1;
      end else begin
        highRun <= highRun + 1;
      end
    end
    prevStep <= phasestep;
    prevBusy <= busy;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic sendReq(input logic [1:0] s, input logic d, input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (req_ready === 1'b1) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (ok) begin
      req_sel   = s;
      req_dir   = d;
      req_count = CNT_W'(n);
      req_valid = 1'b1;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic waitEnd(input int maxCyc, output bit gotDone, output bit gotErr);
    gotDone = 0;
    gotErr  = 0;
    for (int i = 0; i < maxCyc; i++) begin
      tick();
      if (done === 1'b1) begin
        gotDone = 1;
        break;
      end
      if (error === 1'b1) begin
        gotErr = 1;
        break;
      end
    end
  endtask

  function automatic int seqBusy(input int n);
    return (n == 0) ? 1 : SETUP_CYCLES + 2 * STEP_HOLD * n + SETTLE_CYCLES + 2;
  endfunction

  task automatic test_reset();
    int  n;
    bit  seen;
    #12;
    checkCnt++;
    if ({phasesel, phasedir, phasestep, phaseloadreg, busy, done, error, req_ready} !== 9'b00_1_1_1_0_0_0_0)
      $display("FAIL reset_values: got %b want 001110000",
               {phasesel, phasedir, phasestep, phaseloadreg, busy, done, error, req_ready});
    else passCnt++;
    @(negedge clock);
    resetn = 1'b1;
    repeat (4) tick();
    checkCnt++;
    if (req_ready !== 1'b0) $display("FAIL ready_without_lock: got %b want 0", req_ready);
    else passCnt++;
    pll_locked = 1'b1;
    n = 0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n++;
      if (req_ready === 1'b1) begin
        seen = 1;
        break;
      end
    end
    checkCnt++;
    if (!seen || n > 3) $display("FAIL ready_after_lock: seen %0d after %0d cycles want within 3", seen, n);
    else passCnt++;
    checkCnt++;
    if ({phasestep, phaseloadreg, error} !== 3'b110)
      $display("FAIL idle_outputs: got %b want 110", {phasestep, phaseloadreg, error});
    else passCnt++;
  endtask

  task automatic test_steps();
    int  pSel[3] = '{3, 0, 2};
    int  pDir[3] = '{0, 1, 1};
    int  pCnt[3] = '{5, 1, 3};
    bit  ok, gd, ge;
    expT e;
    for (int k = 0; k < 3; k++) begin
      sendReq(2'(pSel[k]), pDir[k][0], pCnt[k], ok);
      checkCnt++;
      if (!ok) $display("FAIL steps_accept[%0d]: ready never seen", k);
      else passCnt++;
      sbQ.push_back('{sel: 2'(pSel[k]), dir: pDir[k][0], pulses: pCnt[k],
                      busyCyc: seqBusy(pCnt[k]), expDone: 1'b1});
      waitEnd(8 * pCnt[k] + 200, gd, ge);
      e = sbQ.pop_front();
      checkCnt++;
      if (gd !== e.expDone || ge) $display("FAIL steps_done[%0d]: done %0d err %0d want done 1", k, gd, ge);
      else passCnt++;
      checkCnt++;
      if (pulseCnt !== e.pulses) $display("FAIL steps_pulses[%0d]: got %0d want %0d", k, pulseCnt, e.pulses);
      else passCnt++;
      checkCnt++;
      if (badLow !== 0 || badHigh !== 0)
        $display("FAIL steps_widths[%0d]: bad low %0d bad high %0d want 0 0", k, badLow, badHigh);
      else passCnt++;
      checkCnt++;
      if (selAtStart !== e.sel || dirAtStart !== e.dir || selChanged)
        $display("FAIL steps_seldir[%0d]: sel %0d dir %0d changed %0d want sel %0d dir %0d stable",
                 k, selAtStart, dirAtStart, selChanged, e.sel, e.dir);
      else passCnt++;
      checkCnt++;
      if (firstFall !== SETUP_CYCLES) $display("FAIL steps_setup[%0d]: got %0d want %0d", k, firstFall, SETUP_CYCLES);
      else passCnt++;
      checkCnt++;
      if (busyCyc !== e.busyCyc) $display("FAIL steps_busy_len[%0d]: got %0d want %0d", k, busyCyc, e.busyCyc);
      else passCnt++;
      checkCnt++;
      if (loadLow) $display("FAIL steps_loadreg[%0d]: got low want high", k);
      else passCnt++;
`ifdef PLL_PHASE_TRACK_EN
      if (k == 0) begin
        checkCnt++;
        if (phase_pos[3] !== 8'hFB) $display("FAIL steps_phase_pos: got %0d want 251 (-5)", phase_pos[3]);
        else passCnt++;
      end
`endif
      tick();
      checkCnt++;
      if (done !== 1'b0 || busy !== 1'b0) $display("FAIL steps_done_pulse[%0d]: done %b busy %b want 0 0", k, done, busy);
      else passCnt++;
    end
  endtask

  task automatic test_zero_count();
    bit  ok, gd, ge;
    expT e;
    sendReq(2'd1, 1'b1, 0, ok);
    checkCnt++;
    if (!ok) $display("FAIL zero_accept: ready never seen");
    else passCnt++;
    sbQ.push_back('{sel: 2'd1, dir: 1'b1, pulses: 0, busyCyc: seqBusy(0), expDone: 1'b1});
    waitEnd(10, gd, ge);
    e = sbQ.pop_front();
    checkCnt++;
    if (gd !== e.expDone || pulseCnt !== e.pulses || busyCyc !== e.busyCyc)
      $display("FAIL zero_count: done %0d pulses %0d busy %0d want 1 %0d %0d", gd, pulseCnt, busyCyc, e.pulses, e.busyCyc);
    else passCnt++;
    tick();
    checkCnt++;
    if (busy !== 1'b0 || done !== 1'b0 || phasestep !== 1'b1)
      $display("FAIL zero_after: busy %b done %b step %b want 0 0 1", busy, done, phasestep);
    else passCnt++;
  endtask

  task automatic test_lock_loss();
    bit  ok, gd, ge, hit;
    expT e;
    sendReq(2'd1, 1'b0, 10, ok);
    checkCnt++;
    if (!ok) $display("FAIL lock_accept: ready never seen");
    else passCnt++;
    sbQ.push_back('{sel: 2'd1, dir: 1'b0, pulses: 3,
                    busyCyc: SETUP_CYCLES + 3 * 2 * STEP_HOLD + SETTLE_CYCLES + LOCK_TIMEOUT, expDone: 1'b0});
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (pulseCnt == 3 && phasestep === 1'b0) begin
        hit = 1;
        break;
      end
    end
    checkCnt++;
    if (!hit) $display("FAIL lock_third_pulse: third pulse never seen");
    else passCnt++;
    pll_locked = 1'b0;
    waitEnd(LOCK_TIMEOUT + 300, gd, ge);
    e = sbQ.pop_front();
    checkCnt++;
    if (ge !== 1'b1 || gd !== e.expDone || doneCyc !== 0)
      $display("FAIL lock_timeout: err %0d done %0d donecyc %0d want 1 0 0", ge, gd, doneCyc);
    else passCnt++;
    checkCnt++;
    if (pulseCnt !== e.pulses || badLow !== 0)
      $display("FAIL lock_pulses: got %0d (bad low %0d) want %0d", pulseCnt, badLow, e.pulses);
    else passCnt++;
    checkCnt++;
    if (busyCyc !== e.busyCyc) $display("FAIL lock_busy_len: got %0d want %0d", busyCyc, e.busyCyc);
    else passCnt++;
    pll_locked = 1'b1;
    repeat (4) tick();
    checkCnt++;
    if (error !== 1'b1 || req_ready !== 1'b0 || phasestep !== 1'b1)
      $display("FAIL lock_sticky: error %b ready %b step %b want 1 0 1", error, req_ready, phasestep);
    else passCnt++;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkCnt++;
    if (error !== 1'b0) $display("FAIL err_clr: got %b want 0", error);
    else passCnt++;
    tick();
    checkCnt++;
    if (req_ready !== 1'b1) $display("FAIL ready_after_clr: got %b want 1", req_ready);
    else passCnt++;
  endtask

  task automatic test_back_to_back();
    bit  ok, gd, early;
    expT e;
    sendReq(2'd1, 1'b1, 2, ok);
    checkCnt++;
    if (!ok) $display("FAIL b2b_accept: ready never seen");
    else passCnt++;
    sbQ.push_back('{sel: 2'd1, dir: 1'b1, pulses: 2, busyCyc: seqBusy(2), expDone: 1'b1});
    req_sel   = 2'd2;
    req_dir   = 1'b0;
    req_count = CNT_W'(1);
    req_valid = 1'b1;
    gd = 0;
    early = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (req_ready === 1'b1) early = 1;
      if (done === 1'b1) begin
        gd = 1;
        break;
      end
    end
    e = sbQ.pop_front();
    checkCnt++;
    if (gd !== e.expDone || early) $display("FAIL b2b_first_done: done %0d ready_while_busy %0d want 1 0", gd, early);
    else passCnt++;
    checkCnt++;
    if (selAtStart !== e.sel || dirAtStart !== e.dir || selChanged || pulseCnt !== e.pulses || busyCyc !== e.busyCyc)
      $display("FAIL b2b_first: sel %0d dir %0d chg %0d pulses %0d busy %0d want %0d %0d 0 %0d %0d",
               selAtStart, dirAtStart, selChanged, pulseCnt, busyCyc, e.sel, e.dir, e.pulses, e.busyCyc);
    else passCnt++;
    tick();
    checkCnt++;
    if (req_ready !== 1'b1) $display("FAIL b2b_ready_after_done: got %b want 1", req_ready);
    else passCnt++;
    sbQ.push_back('{sel: 2'd2, dir: 1'b0, pulses: 1, busyCyc: seqBusy(1), expDone: 1'b1});
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    waitEnd(200, gd, ok);
    e = sbQ.pop_front();
    checkCnt++;
    if (gd !== e.expDone || selAtStart !== e.sel || dirAtStart !== e.dir || pulseCnt !== e.pulses || busyCyc !== e.busyCyc)
      $display("FAIL b2b_second: done %0d sel %0d dir %0d pulses %0d busy %0d want 1 %0d %0d %0d %0d",
               gd, selAtStart, dirAtStart, pulseCnt, busyCyc, e.sel, e.dir, e.pulses, e.busyCyc);
    else passCnt++;
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok, hit;
    sendReq(2'd3, 1'b1, 4, ok);
    hit = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (phasestep === 1'b0) begin
        hit = 1;
        break;
      end
    end
    checkCnt++;
    if (!ok || !hit) $display("FAIL rstmid_low_pulse: accept %0d low seen %0d want 1 1", ok, hit);
    else passCnt++;
    #2;
    resetn = 1'b0;
    #1;
    checkCnt++;
    if ({phasestep, busy, phasesel, phasedir, done} !== 6'b1_0_00_1_0)
      $display("FAIL rstmid_async: step %b busy %b sel %0d dir %b done %b want 1 0 0 1 0",
               phasestep, busy, phasesel, phasedir, done);
    else passCnt++;
    @(negedge clock);
    resetn = 1'b1;
    repeat (4) tick();
    checkCnt++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || phasestep !== 1'b1 || done !== 1'b0)
      $display("FAIL rstmid_idle: busy %b ready %b step %b done %b want 0 1 1 0", busy, req_ready, phasestep, done);
    else passCnt++;
    checkCnt++;
    if (sbQ.size() !== 0) $display("FAIL scoreboard_empty: got %0d entries want 0", sbQ.size());
    else passCnt++;
  endtask

  initial begin
    test_reset();
    test_steps();
    test_zero_count();
    test_lock_loss();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
